// File: rtl/gba_mem_ctrl_if.sv
// Bus bundle between the CPU/loader requesters, the memory controller and the
// region backends. The controller uses the slave view; the environment drives the master view.
interface gba_mem_ctrl_if #(
  parameter int LDR_AW = 23
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_width;
  logic              cpu_write;
  logic              cpu_ok;
  logic [31:0]       cpu_rdata;
  logic              ldr_valid;
  logic [LDR_AW-1:0] ldr_addr;
  logic [31:0]       ldr_data;
  logic              ldr_ready;
  logic              bk_en;
  logic              bk_we;
  logic [3:0]        bk_region;
  logic [23:0]       bk_addr;
  logic [3:0]        bk_be;
  logic [31:0]       bk_wdata;
  logic [31:0]       bk_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_width, cpu_write,
    output ldr_valid, ldr_addr, ldr_data, bk_rdata,
    input  cpu_ok, cpu_rdata, ldr_ready,
    input  bk_en, bk_we, bk_region, bk_addr, bk_be, bk_wdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_width, cpu_write,
    input  ldr_valid, ldr_addr, ldr_data, bk_rdata,
    output cpu_ok, cpu_rdata, ldr_ready,
    output bk_en, bk_we, bk_region, bk_addr, bk_be, bk_wdata
  );
endinterface

// File: rtl/gba_mem_ctrl.sv
// GBA memory controller: loader/CPU arbitration, memory-map decode, one backend
// access per request with per-region wait states, lane enables, read rotation and open bus.
module gba_mem_ctrl #(
  parameter int WS_BIOS  = 0,
  parameter int WS_EWRAM = 2,
  parameter int WS_IWRAM = 0,
  parameter int WS_IO    = 0,
  parameter int WS_VID   = 0,
  parameter int WS_PAK_N = 4,
  parameter int WS_PAK_S = 2,
  parameter int WS_SRAM  = 4,
  parameter int LDR_AW   = 23,
  parameter int WS_W     = 4
) (
  input  logic          clk,
  input  logic          rst,
  gba_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [31:0] LDR_BASE = 32'h0800_0000;

  function automatic logic [3:0] f_be(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      2'd0:    f_be = 4'b0001 << lo;
      2'd1:    f_be = lo[1] ? 4'b1100 : 4'b0011;
      default: f_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] width, input logic [31:0] d);
    case (width)
      2'd0:    f_wdata = {4{d[7:0]}};
      2'd1:    f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  // Word-align within the region; VRAM folds its upper 32K mirror onto 0x10000-0x17FFF.
  function automatic logic [23:0] f_fold(input logic [3:0] region, input logic [23:0] a);
    f_fold = {a[23:2], 2'b00};
    if (region == 4'h6 && a[16]) f_fold[15] = 1'b0;
  endfunction

  function automatic logic [31:0] f_align(input logic [1:0] width, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [31:0] r;
    case (lo)
      2'd0:    r = d;
      2'd1:    r = {d[7:0],  d[31:8]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[23:0], d[31:24]};
    endcase
    case (width)
      2'd0:    f_align = {24'h0, r[7:0]};
      2'd1:    f_align = {16'h0, r[15:0]};
      default: f_align = r;
    endcase
  endfunction

  function automatic logic [WS_W-1:0] f_ws(input logic [3:0] region, input logic seq,
                                           input logic ldr);
    if (ldr) begin
      f_ws = '0;
    end else begin
      case (region)
        4'h0:                      f_ws = WS_W'(WS_BIOS);
        4'h2:                      f_ws = WS_W'(WS_EWRAM);
        4'h3:                      f_ws = WS_W'(WS_IWRAM);
        4'h4:                      f_ws = WS_W'(WS_IO);
        4'h5, 4'h6, 4'h7:          f_ws = WS_W'(WS_VID);
        4'h8, 4'h9, 4'hA,
        4'hB, 4'hC, 4'hD:          f_ws = seq ? WS_W'(WS_PAK_S) : WS_W'(WS_PAK_N);
        4'hE, 4'hF:                f_ws = WS_W'(WS_SRAM);
        default:                   f_ws = '0;
      endcase
    end
  endfunction

  state_t          state_q;
  logic            src_ldr_q;
  logic            rd_q;
  logic            issued_q;
  logic            first_q;
  logic [1:0]      width_q;
  logic [1:0]      lane_q;
  logic [WS_W-1:0] ws_q;
  logic [WS_W-1:0] cnt_q;
  logic [31:0]     cap_q;
  logic [31:0]     obus_q;
  logic [31:0]     prev_addr_q;
  logic            prev_valid_q;
  logic            cpu_ok_q;
  logic            ldr_ready_q;
  logic [31:0]     cpu_rdata_q;
  logic            bk_en_q;
  logic            bk_we_q;
  logic [3:0]      bk_region_q;
  logic [23:0]     bk_addr_q;
  logic [3:0]      bk_be_q;
  logic [31:0]     bk_wdata_q;

  logic            use_ldr;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [1:0]      req_width;
  logic            req_write;
  logic [3:0]      req_region;
  logic            req_pak;
  logic            req_mapped;
  logic            issue_d;
  logic [31:0]     step_d;
  logic            seq_d;
  logic [WS_W-1:0] ws_d;
  logic [23:0]     bk_addr_d;
  logic [3:0]      bk_be_d;
  logic [31:0]     bk_wdata_d;

  // Request decode from the live inputs; only consumed in IDLE, so later changes are ignored.
  always_comb begin
    use_ldr    = bus.ldr_valid;
    req_addr   = use_ldr ? LDR_BASE + 32'({bus.ldr_addr, 2'b00}) : bus.cpu_addr;
    req_wdata  = use_ldr ? bus.ldr_data : bus.cpu_wdata;
    req_width  = use_ldr ? 2'd2 : bus.cpu_width;
    req_write  = use_ldr | bus.cpu_write;
    req_region = req_addr[27:24];
    req_pak    = (req_region >= 4'h8) && (req_region <= 4'hD);
    req_mapped = (req_region != 4'h1);
    issue_d    = req_mapped && !((req_region == 4'h0) && req_write);
    case (req_width)
      2'd0:    step_d = 32'd1;
      2'd1:    step_d = 32'd2;
      default: step_d = 32'd4;
    endcase
    seq_d      = prev_valid_q && req_pak && (req_addr == prev_addr_q + step_d);
    ws_d       = f_ws(req_region, seq_d, use_ldr);
    bk_addr_d  = f_fold(req_region, req_addr[23:0]);
    bk_be_d    = f_be(req_width, req_addr[1:0]);
    bk_wdata_d = f_wdata(req_width, req_wdata);
  end

  // Backend data is live in the cycle after bk_en and captured for longer waits.
  logic [31:0] rd_raw;
  logic [31:0] rd_val;
  assign rd_raw = first_q ? bus.bk_rdata : cap_q;
  assign rd_val = issued_q ? f_align(width_q, lane_q, rd_raw) : obus_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_ldr_q    <= 1'b0;
      rd_q         <= 1'b0;
      issued_q     <= 1'b0;
      first_q      <= 1'b0;
      width_q      <= 2'd0;
      lane_q       <= 2'd0;
      ws_q         <= '0;
      cnt_q        <= '0;
      obus_q       <= '0;
      prev_valid_q <= 1'b0;
      cpu_ok_q     <= 1'b0;
      ldr_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      bk_en_q      <= 1'b0;
      bk_we_q      <= 1'b0;
      bk_region_q  <= '0;
      bk_addr_q    <= '0;
      bk_be_q      <= '0;
      bk_wdata_q   <= '0;
    end else begin
      cpu_ok_q    <= 1'b0;
      ldr_ready_q <= 1'b0;
      bk_en_q     <= 1'b0;
      bk_we_q     <= 1'b0;
      first_q     <= 1'b0;

      if (first_q && rd_q) begin
        cap_q  <= bus.bk_rdata;
        obus_q <= bus.bk_rdata;
      end
      if (cpu_ok_q && rd_q) cpu_rdata_q <= rd_val;

      case (state_q)
        S_IDLE: begin
          if (bus.ldr_valid || bus.cpu_req) begin
            src_ldr_q   <= use_ldr;
            rd_q        <= !req_write;
            issued_q    <= issue_d;
            width_q     <= req_width;
            lane_q      <= req_addr[1:0];
            ws_q        <= ws_d;
            bk_en_q     <= issue_d;
            bk_we_q     <= issue_d && req_write;
            bk_region_q <= req_region;
            bk_addr_q   <= bk_addr_d;
            bk_be_q     <= bk_be_d;
            bk_wdata_q  <= bk_wdata_d;
            if (!use_ldr) begin
              prev_valid_q <= req_pak;
              if (req_pak) prev_addr_q <= req_addr;
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= ws_q;
          first_q <= issued_q;
          if (ws_q == '0) begin
            cpu_ok_q    <= !src_ldr_q;
            ldr_ready_q <= src_ldr_q;
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The ok pulse is raised one edge early so it is visible exactly while cnt_q == 0.
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - WS_W'(1);
            if (cnt_q == WS_W'(1)) begin
              cpu_ok_q    <= !src_ldr_q;
              ldr_ready_q <= src_ldr_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ok    = cpu_ok_q;
  assign bus.cpu_rdata = (cpu_ok_q && rd_q) ? rd_val : cpu_rdata_q;
  assign bus.ldr_ready = ldr_ready_q;
  assign bus.bk_en     = bk_en_q;
  assign bus.bk_we     = bk_we_q;
  assign bus.bk_region = bk_region_q;
  assign bus.bk_addr   = bk_addr_q;
  assign bus.bk_be     = bk_be_q;
  assign bus.bk_wdata  = bk_wdata_q;

endmodule
